// File: rtl/rmt_stream_wrapper_pkg.sv
// Shared header-field offsets, protocol constants and the action-entry layout
// used by the RMT stream block and its action table.
package rmt_stream_wrapper_pkg;

  localparam int DATA_W = 512;
  localparam int KEEP_W = DATA_W / 8;
  localparam int USER_W = 128;
  localparam int ENT_W  = 32;

  localparam int ETYPE_LSB       = 128;
  localparam int PROTO_LSB       = 216;
  localparam int UDP_DPORT_LSB   = 320;
  localparam int VID_LSB         = 120;
  localparam int MODID_LSB       = 368;
  localparam int INDEX_LSB       = 384;
  localparam int TUSER_DPORT_LSB = 24;

  localparam logic [15:0] CTL_UDP_PORT = 16'hf1f2;
  localparam logic [15:0] IPV4_ETYPE   = 16'h0008;
  localparam logic [7:0]  UDP_PROTO    = 8'h11;

  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [USER_W-1:0] tuser;
    logic              tlast;
  } beat_t;

  typedef struct packed {
    logic        vld;
    logic        drop;
    logic        set_port;
    logic        set_tuser;
    logic [3:0]  rsvd;
    logic [7:0]  tuser_port;
    logic [15:0] udp_port;
  } entry_t;

  function automatic logic is_ipv4_udp(input logic [15:0] etype, input logic [7:0] proto);
    return (etype == IPV4_ETYPE) && (proto == UDP_PROTO);
  endfunction

endpackage

// File: rtl/rmt_action_table.sv
// Action table register file: one synchronous write port, one asynchronous read port.
// Write lands on the clock edge; the read port reflects it from the next cycle on.
module rmt_action_table
  import rmt_stream_wrapper_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = ENT_W
) (
  input  logic          clk,
  input  logic          aresetn,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdat,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdat
);

  logic [2**AW-1:0][DW-1:0] r_mem;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_mem <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdat;
    end
  end

  assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/rmt_stream_wrapper.sv
// Single-stage RMT block: control packets program the action table, data packets are forwarded, rewritten or dropped.
// Two register stages (2-cycle latency); s_axis_tready follows the pipeline advance, so a stalled output holds both stages.
module rmt_stream_wrapper
  import rmt_stream_wrapper_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH   = 32,
  parameter int          C_S_AXI_ADDR_WIDTH   = 12,
  parameter logic [31:0] C_BASEADDR           = 32'h80000000,
  parameter int          C_S_AXIS_DATA_WIDTH  = 512,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter int          C_M_AXIS_DATA_WIDTH  = 512,
  parameter int          PHV_ADDR_WIDTH       = 4
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast
);

  logic                      r_sop;
  logic                      r_s1_vld;
  logic                      r_s1_sop;
  beat_t                     r_s1_dat;
  logic                      r_s2_vld;
  beat_t                     r_s2_dat;
  logic                      r_pkt_ctl;
  logic                      r_pkt_drop;
  logic                      r_ctl_second;
  logic                      r_ctl_wr_ok;
  logic [PHV_ADDR_WIDTH-1:0] r_ctl_idx;

  logic                      w_adv;
  logic                      w_move;
  logic                      w_is_udp;
  logic                      w_is_ctl;
  logic                      w_ctl;
  logic                      w_drop;
  logic                      w_tbl_we;
  logic [ENT_W-1:0]          w_entry_raw;
  entry_t                    w_entry;
  beat_t                     w_out;
  logic [31:0]               w_unused_cfg;
  logic [3:0]                w_unused_ent;

  assign w_adv         = !r_s2_vld || m_axis_tready;
  assign w_move        = w_adv && r_s1_vld;
  assign s_axis_tready = w_adv;

  // Header decode works on the S1 beat; only meaningful when r_s1_sop is set.
  assign w_is_udp = is_ipv4_udp(r_s1_dat.tdata[ETYPE_LSB +: 16], r_s1_dat.tdata[PROTO_LSB +: 8]);
  assign w_is_ctl = w_is_udp && (r_s1_dat.tdata[UDP_DPORT_LSB +: 16] == CTL_UDP_PORT);
  assign w_entry  = entry_t'(w_entry_raw);

  assign w_ctl  = r_s1_sop ? w_is_ctl : r_pkt_ctl;
  assign w_drop = r_s1_sop ? (!w_is_ctl && w_entry.vld && w_entry.drop) : r_pkt_drop;

  assign w_tbl_we = w_move && !r_s1_sop && r_ctl_second && r_ctl_wr_ok;

  rmt_action_table #(
    .AW (PHV_ADDR_WIDTH),
    .DW (ENT_W)
  ) u_tbl (
    .clk     (clk),
    .aresetn (aresetn),
    .i_we    (w_tbl_we),
    .i_waddr (r_ctl_idx),
    .i_wdat  (r_s1_dat.tdata[ENT_W-1:0]),
    .i_raddr (r_s1_dat.tdata[VID_LSB +: PHV_ADDR_WIDTH]),
    .o_rdat  (w_entry_raw)
  );

  always_comb begin
    w_out = r_s1_dat;
    if (r_s1_sop && !w_is_ctl && w_entry.vld) begin
      if (w_entry.set_port && w_is_udp) begin
        w_out.tdata[UDP_DPORT_LSB +: 16] = w_entry.udp_port;
      end
      if (w_entry.set_tuser) begin
        w_out.tuser[TUSER_DPORT_LSB +: 8] = w_entry.tuser_port;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_sop    <= 1'b1;
      r_s1_vld <= 1'b0;
      r_s1_sop <= 1'b0;
      r_s1_dat <= '0;
      r_s2_vld <= 1'b0;
      r_s2_dat <= '0;
    end else if (w_adv) begin
      r_s1_vld <= s_axis_tvalid;
      r_s1_sop <= r_sop;
      r_s1_dat <= {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
      if (s_axis_tvalid) begin
        r_sop <= s_axis_tlast;
      end
      r_s2_vld <= r_s1_vld && !w_ctl && !w_drop;
      r_s2_dat <= w_out;
    end
  end

  // Per-packet decisions are taken on the first beat and held until the next one.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_pkt_ctl    <= 1'b0;
      r_pkt_drop   <= 1'b0;
      r_ctl_second <= 1'b0;
      r_ctl_wr_ok  <= 1'b0;
      r_ctl_idx    <= '0;
    end else if (w_move) begin
      if (r_s1_sop) begin
        r_pkt_ctl    <= w_is_ctl;
        r_pkt_drop   <= w_drop;
        r_ctl_second <= w_is_ctl && !r_s1_dat.tlast;
        r_ctl_wr_ok  <= (r_s1_dat.tdata[MODID_LSB +: 8] == 8'h00) &&
                        (r_s1_dat.tdata[INDEX_LSB + PHV_ADDR_WIDTH +: 8 - PHV_ADDR_WIDTH] == '0);
        r_ctl_idx    <= r_s1_dat.tdata[INDEX_LSB +: PHV_ADDR_WIDTH];
      end else begin
        r_ctl_second <= 1'b0;
      end
    end
  end

  assign m_axis_tvalid = r_s2_vld;
  assign m_axis_tdata  = r_s2_dat.tdata;
  assign m_axis_tkeep  = r_s2_dat.tkeep;
  assign m_axis_tuser  = r_s2_dat.tuser;
  assign m_axis_tlast  = r_s2_dat.tlast;

  assign w_unused_cfg = C_BASEADDR ^ 32'(C_S_AXI_DATA_WIDTH) ^ 32'(C_S_AXI_ADDR_WIDTH);
  assign w_unused_ent = w_entry.rsvd;

endmodule

// File: tb/tb_rmt_stream_wrapper.sv
// Directed bench for rmt_stream_wrapper: packet-level table model feeds a scoreboard
// queue that an output monitor drains and compares on each accepted output beat.
module tb_rmt_stream_wrapper;

  localparam logic [15:0] ET_IPV4 = 16'h0008;
  localparam logic [15:0] ET_ARP  = 16'h0608;
  localparam logic [7:0]  PR_UDP  = 8'h11;
  localparam logic [15:0] CTL     = 16'hf1f2;

  logic         clk = 1'b0;
  logic         aresetn;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;

  always #5 clk = ~clk;

  rmt_stream_wrapper dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  typedef struct packed {
    logic [511:0] d;
    logic [63:0]  k;
    logic [127:0] u;
    logic         l;
  } bt_t;

  bt_t          pkt[$];
  bt_t          exp_q[$];
  logic [31:0]  tbl[16];
  int           n_cmp = 0;
  int           n_mis = 0;
  int           cyc = 0;
  int           acc_cyc = 0;
  int           first_acc = 0;
  int           out_cyc = 0;
  bit           lat_arm = 1'b0;
  bt_t          mon_e;
  bit           mon_have;
  logic [511:0] held;
  logic [511:0] hdr;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (aresetn === 1'b1 && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      if (lat_arm) begin
        out_cyc = cyc;
        lat_arm = 1'b0;
      end
      mon_have = (exp_q.size() != 0);
      n_cmp++;
      assert (mon_have === 1'b1) else begin
        n_mis++;
        $error("FAIL unexpected_beat got tdata[63:0]=%h exp no beat", m_axis_tdata[63:0]);
      end
      if (mon_have) begin
        mon_e = exp_q.pop_front();
        n_cmp++;
        assert (m_axis_tdata === mon_e.d) else begin
          n_mis++;
          $error("FAIL tdata got %h exp %h", m_axis_tdata, mon_e.d);
        end
        n_cmp++;
        assert ({m_axis_tuser, m_axis_tkeep, m_axis_tlast} === {mon_e.u, mon_e.k, mon_e.l}) else begin
          n_mis++;
          $error("FAIL user_keep_last got %h exp %h", {m_axis_tuser, m_axis_tkeep, m_axis_tlast},
                 {mon_e.u, mon_e.k, mon_e.l});
        end
      end
    end
  end

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] mk_hdr(input logic [15:0] et, input logic [7:0] pr,
                                          input logic [15:0] dp, input logic [11:0] vid,
                                          input logic [7:0] mid, input logic [7:0] idx);
    logic [511:0] r;
    r = rnd512();
    r[143:128] = et;
    r[223:216] = pr;
    r[335:320] = dp;
    r[115:112] = vid[11:8];
    r[127:120] = vid[7:0];
    r[375:368] = mid;
    r[391:384] = idx;
    return r;
  endfunction

  task automatic build(input int n, input logic [511:0] h, input logic [127:0] u0, input logic [31:0] w2);
    bt_t b;
    pkt.delete();
    for (int i = 0; i < n; i++) begin
      b.d = (i == 0) ? h : rnd512();
      if (i == 1) b.d[31:0] = w2;
      b.k = (i == n - 1) ? 64'h0000_0000_FFFF_FFFF : '1;
      b.u = (i == 0) ? u0 : {$urandom, $urandom, $urandom, $urandom};
      b.l = (i == n - 1);
      pkt.push_back(b);
    end
  endtask

  task automatic drive_beat(input bt_t b);
    bit done;
    int t;
    done = 1'b0;
    t = 0;
    s_axis_tdata  = b.d;
    s_axis_tkeep  = b.k;
    s_axis_tuser  = b.u;
    s_axis_tlast  = b.l;
    s_axis_tvalid = 1'b1;
    while (!done && t < 100) begin
      @(negedge clk);
      done = (s_axis_tready === 1'b1);
      if (done) acc_cyc = cyc;
      @(posedge clk);
      #1;
      t++;
    end
    s_axis_tvalid = 1'b0;
    n_cmp++;
    assert (done) else begin
      n_mis++;
      $error("FAIL accept_timeout got ready=%0b exp 1", done);
    end
  endtask

  // Packet-level reference: control packets update the model table, data packets
  // look it up by vid[3:0] and push their expected output beats.
  task automatic send_pkt();
    logic [511:0] d0;
    logic         udp;
    logic         ctl;
    logic [31:0]  e;
    bt_t          b;
    d0  = pkt[0].d;
    udp = (d0[143:128] == ET_IPV4) && (d0[223:216] == PR_UDP);
    ctl = udp && (d0[335:320] == CTL);
    if (ctl) begin
      if (pkt.size() > 1 && d0[375:368] == 8'h00 && d0[391:388] == 4'h0)
        tbl[d0[387:384]] = pkt[1].d[31:0];
    end else begin
      e = tbl[d0[123:120]];
      if (!(e[31] && e[30])) begin
        for (int i = 0; i < pkt.size(); i++) begin
          b = pkt[i];
          if (i == 0 && e[31]) begin
            if (e[29] && udp) b.d[335:320] = e[15:0];
            if (e[28]) b.u[31:24] = e[23:16];
          end
          exp_q.push_back(b);
        end
      end
    end
    for (int i = 0; i < pkt.size(); i++) begin
      drive_beat(pkt[i]);
      if (i == 0) first_acc = acc_cyc;
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_mis++;
      $error("FAIL drain got %0d beats left exp 0", exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) tbl[i] = 32'h0;
    aresetn       = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;

    repeat (3) @(negedge clk);
    n_cmp++;
    assert (m_axis_tvalid === 1'b0) else begin n_mis++; $error("FAIL rst_tvalid got %b exp 0", m_axis_tvalid); end
    n_cmp++;
    assert (m_axis_tdata === '0) else begin n_mis++; $error("FAIL rst_tdata got %h exp 0", m_axis_tdata); end
    n_cmp++;
    assert ({m_axis_tkeep, m_axis_tuser, m_axis_tlast} === '0) else begin
      n_mis++; $error("FAIL rst_keep_user_last got %h exp 0", {m_axis_tkeep, m_axis_tuser, m_axis_tlast});
    end
    n_cmp++;
    assert (s_axis_tready === 1'b1) else begin n_mis++; $error("FAIL rst_tready got %b exp 1", s_axis_tready); end
    @(posedge clk);
    #1 aresetn = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Empty table: 4-beat UDP packet forwards unchanged with 2-cycle latency.
    lat_arm = 1'b1;
    build(4, mk_hdr(ET_IPV4, PR_UDP, 16'h1111, 12'h000, 8'h5A, 8'hA5), 128'h0, $urandom);
    send_pkt();
    wait_drain();
    n_cmp++;
    assert (out_cyc - first_acc === 2) else begin
      n_mis++; $error("FAIL latency got %0d exp 2", out_cyc - first_acc);
    end

    // Entry 0 rewrites the UDP dst port; upper vid bits must not matter.
    build(3, mk_hdr(ET_IPV4, PR_UDP, CTL, 12'h000, 8'h00, 8'h00), 128'h0, 32'hA000_1234);
    send_pkt();
    build(4, mk_hdr(ET_IPV4, PR_UDP, 16'h1111, 12'h120, 8'h00, 8'h00), 128'h0, $urandom);
    send_pkt();
    wait_drain();

    // Drop entry at index 2; vid 0 packet after it still forwards.
    build(2, mk_hdr(ET_IPV4, PR_UDP, CTL, 12'h000, 8'h00, 8'h02), 128'h0, 32'hC000_0000);
    send_pkt();
    build(4, mk_hdr(ET_IPV4, PR_UDP, 16'h3333, 12'h002, 8'h00, 8'h00), 128'h0, $urandom);
    send_pkt();
    build(3, mk_hdr(ET_IPV4, PR_UDP, 16'h4444, 12'h000, 8'h00, 8'h00), 128'h0, $urandom);
    send_pkt();
    wait_drain();

    // Rejected writes: mod_id 1, index above 15, and a single-beat control packet.
    hdr = mk_hdr(ET_IPV4, PR_UDP, CTL, 12'h000, 8'h01, 8'h03);
    hdr[383:380] = 4'h1;
    build(2, hdr, 128'h0, 32'hC000_0000);
    send_pkt();
    build(2, mk_hdr(ET_IPV4, PR_UDP, CTL, 12'h000, 8'h00, 8'h10), 128'h0, 32'hC000_0000);
    send_pkt();
    build(1, mk_hdr(ET_IPV4, PR_UDP, CTL, 12'h000, 8'h00, 8'h04), 128'h0, 32'h0);
    send_pkt();
    build(3, mk_hdr(ET_IPV4, PR_UDP, 16'h5555, 12'h003, 8'h00, 8'h00), 128'h0, $urandom);
    send_pkt();
    build(2, mk_hdr(ET_IPV4, PR_UDP, 16'h6666, 12'h000, 8'h00, 8'h00), 128'h0, $urandom);
    send_pkt();
    build(2, mk_hdr(ET_IPV4, PR_UDP, 16'h7777, 12'h004, 8'h00, 8'h00), 128'h0, $urandom);
    send_pkt();
    wait_drain();

    // tuser rewrite only; then set_port on a non-UDP and a UDP packet.
    build(2, mk_hdr(ET_IPV4, PR_UDP, CTL, 12'h000, 8'h00, 8'h00), 128'h0, 32'h9005_0000);
    send_pkt();
    build(3, mk_hdr(ET_IPV4, PR_UDP, 16'h8888, 12'h000, 8'h00, 8'h00), 128'h0, $urandom);
    send_pkt();
    build(2, mk_hdr(ET_IPV4, PR_UDP, CTL, 12'h000, 8'h00, 8'h05), 128'h0, 32'hA000_BEEF);
    send_pkt();
    build(2, mk_hdr(ET_ARP, PR_UDP, 16'h9999, 12'h005, 8'h00, 8'h00), 128'h0, $urandom);
    send_pkt();
    build(2, mk_hdr(ET_IPV4, PR_UDP, 16'h9999, 12'h005, 8'h00, 8'h00), 128'h0, $urandom);
    send_pkt();
    wait_drain();

    // Output stall mid-packet: input blocked, output beat held stable.
    build(6, mk_hdr(ET_IPV4, PR_UDP, 16'h2222, 12'h007, 8'h00, 8'h00), 128'h0, $urandom);
    fork
      send_pkt();
      begin
        repeat (3) @(posedge clk);
        #1 m_axis_tready = 1'b0;
        @(negedge clk);
        held = m_axis_tdata;
        for (int i = 0; i < 5; i++) begin
          n_cmp++;
          assert (s_axis_tready === 1'b0 && m_axis_tvalid === 1'b1 && m_axis_tdata === held) else begin
            n_mis++;
            $error("FAIL stall got rdy=%b vld=%b same=%b exp 0 1 1", s_axis_tready, m_axis_tvalid,
                   m_axis_tdata === held);
          end
          @(negedge clk);
        end
        @(posedge clk);
        #1 m_axis_tready = 1'b1;
      end
    join
    wait_drain();

    // Reset in the middle of a dropped packet: table clears, next beat is a first beat.
    build(4, mk_hdr(ET_IPV4, PR_UDP, 16'h1212, 12'h002, 8'h00, 8'h00), 128'h0, $urandom);
    drive_beat(pkt[0]);
    drive_beat(pkt[1]);
    #1 aresetn = 1'b0;
    for (int i = 0; i < 16; i++) tbl[i] = 32'h0;
    @(posedge clk);
    #1 aresetn = 1'b1;
    build(3, mk_hdr(ET_IPV4, PR_UDP, 16'h1313, 12'h002, 8'h00, 8'h00), 128'h0, $urandom);
    send_pkt();
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
